// File: rtl/mic_pkg.sv
// Shared constants, state encoding and helpers for the I2S microphone capture block.
package mic_pkg;

    localparam int SLOT_BITS     = 32;
    localparam int FRAME_BITS    = 64;
    localparam int MIC_WORD_BITS = 24;
    localparam int SAMPLE_BITS   = 16;
    localparam int BIT_CNT_W     = $clog2(FRAME_BITS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mic_state_e;

    // Keep the top SAMPLE_BITS of a microphone word; plain truncation, no rounding.
    function automatic logic [SAMPLE_BITS-1:0] truncSample(input logic [MIC_WORD_BITS-1:0] word);
        return word[MIC_WORD_BITS-1 -: SAMPLE_BITS];
    endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock divider: toggles sck every CLK_DIV clks while run_i is high and
// provides single-clk strobes on the clk at which sck rises or falls.
module i2s_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic sck_o,
    output logic sck_rise_o,
    output logic sck_fall_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] divCnt_q;
    logic [7:0] divCnt_d;
    logic       sck_q;
    logic       sck_d;
    logic       wrap;

    // Next divider count and bit-clock level; sck flips whenever the divider wraps.
    always_comb begin
        wrap     = run_i && (divCnt_q == DIV_LAST);
        divCnt_d = wrap ? 8'd0 : divCnt_q + 8'd1;
        sck_d    = wrap ? ~sck_q : sck_q;
    end

    // Divider and sck registers, parked at zero while the parent is idle.
    always_ff @(posedge clk) begin
        if (rst || !run_i) begin
            divCnt_q <= 8'd0;
            sck_q    <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            sck_q    <= sck_d;
        end
    end

    assign sck_o      = sck_q;
    assign sck_rise_o = wrap && !sck_q;
    assign sck_fall_o = wrap && sck_q;

endmodule

// File: rtl/i2s_mic_capture.sv
// I2S microphone capture: generates SCK/WS for a left-channel 24-bit mic, shifts
// in the left word and writes its upper 16 bits to a downstream FIFO once per frame.
// Optional macro I2S_MIC_OVF_CNT_EN adds the ovf_cnt port counting dropped samples.
module i2s_mic_capture
    import mic_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int STARTUP_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic                   i2s_sck,
    output logic                   i2s_ws,
    input  logic                   i2s_sd,
    input  logic                   fifo_full,
    output logic                   wr_en,
    output logic [SAMPLE_BITS-1:0] din
`ifdef I2S_MIC_OVF_CNT_EN
    ,
    output logic [15:0]            ovf_cnt
`endif
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] WORD_LAST   = BIT_CNT_W'(MIC_WORD_BITS);
    localparam logic [7:0]           STARTUP_LIM = 8'(STARTUP_FRAMES);

    mic_state_e                 state_q;
    logic [BIT_CNT_W-1:0]       bitCnt_q;
    logic [7:0]                 frameCnt_q;
    logic [MIC_WORD_BITS-1:0]   shift_q;
    logic                       capDone_q;
    logic                       wrEn_q;
    logic [SAMPLE_BITS-1:0]     din_q;

    logic running;
    logic sckRise;
    logic sckFall;
    logic inWord;
    logic writeSlot;

    i2s_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk        (clk),
        .rst        (rst),
        .run_i      (running),
        .sck_o      (i2s_sck),
        .sck_rise_o (sckRise),
        .sck_fall_o (sckFall)
    );

    assign running = (state_q == RUN);

    // Bits 1..24 of the left slot carry the word; bit 0 is the I2S one-bit delay.
    assign inWord = (bitCnt_q != '0) && (bitCnt_q <= WORD_LAST);

    // A write attempt happens once the word is complete and the startup frames are over.
    assign writeSlot = capDone_q && (frameCnt_q == STARTUP_LIM);

    // Capture controller: state, frame position, word shifting and the FIFO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            frameCnt_q <= '0;
            shift_q    <= '0;
            capDone_q  <= 1'b0;
            wrEn_q     <= 1'b0;
            din_q      <= '0;
        end else begin
            wrEn_q    <= 1'b0;
            capDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    bitCnt_q   <= '0;
                    frameCnt_q <= '0;
                    if (enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (sckRise && inWord) begin
                        shift_q <= {shift_q[MIC_WORD_BITS-2:0], i2s_sd};
                    end
                    if (sckRise && (bitCnt_q == WORD_LAST)) begin
                        capDone_q <= 1'b1;
                    end
                    if (writeSlot && !fifo_full) begin
                        wrEn_q <= 1'b1;
                        din_q  <= truncSample(shift_q);
                    end
                    if (sckFall) begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                        if (bitCnt_q == LAST_BIT) begin
                            if (frameCnt_q != STARTUP_LIM) begin
                                frameCnt_q <= frameCnt_q + 8'd1;
                            end
                            if (!enable) begin
                                state_q    <= IDLE;
                                frameCnt_q <= '0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i2s_ws = bitCnt_q[BIT_CNT_W-1];
    assign wr_en  = wrEn_q;
    assign din    = din_q;

`ifdef I2S_MIC_OVF_CNT_EN
    logic [15:0] ovfCnt_q;
    logic [15:0] ovfCnt_d;
    logic        dropSample;

    assign dropSample = writeSlot && fifo_full;

    // Saturating count of samples lost to a full FIFO.
    always_comb begin
        ovfCnt_d = ovfCnt_q;
        if (dropSample && (ovfCnt_q != 16'hFFFF)) begin
            ovfCnt_d = ovfCnt_q + 16'd1;
        end
    end

    // Overflow counter register; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovfCnt_q <= 16'd0;
        end else begin
            ovfCnt_q <= ovfCnt_d;
        end
    end

    assign ovf_cnt = ovfCnt_q;
`endif

endmodule

// File: tb/tb_i2s_mic_capture.sv
// Self-checking bench for i2s_mic_capture: two instances (no startup frames and two
// startup frames) share stimulus from a bench-side microphone/FIFO model.
module tb_i2s_mic_capture;

    localparam int CLK_DIV = 4;
    localparam int NV      = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        i2s_sd;
    logic        fifo_full;
    logic        sck0, ws0, wr0;
    logic        sck2, ws2, wr2;
    logic [15:0] din0, din2;
`ifdef I2S_MIC_OVF_CNT_EN
    logic [15:0] ovf0, ovf2;
`endif

    int nApplied = 0;
    int nMiss    = 0;

    // Clock
    always #5 clk = ~clk;

    i2s_mic_capture #(.CLK_DIV(CLK_DIV), .STARTUP_FRAMES(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .i2s_sck(sck0), .i2s_ws(ws0),
        .i2s_sd(i2s_sd), .fifo_full(fifo_full), .wr_en(wr0), .din(din0)
`ifdef I2S_MIC_OVF_CNT_EN
        , .ovf_cnt(ovf0)
`endif
    );

    i2s_mic_capture #(.CLK_DIV(CLK_DIV), .STARTUP_FRAMES(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .i2s_sck(sck2), .i2s_ws(ws2),
        .i2s_sd(i2s_sd), .fifo_full(fifo_full), .wr_en(wr2), .din(din2)
`ifdef I2S_MIC_OVF_CNT_EN
        , .ovf_cnt(ovf2)
`endif
    );

    // Monitor state, written only by the monitor processes below
    int   cyc        = 0;
    int   wrCnt0     = 0;
    int   wrCnt2     = 0;
    int   lastRise   = -1;
    int   sckPeriod  = 0;
    int   wsRun      = 0;
    int   wsLowLen   = 0;
    int   wsHighLen  = 0;
    logic prevSck    = 1'b0;
    logic prevWs     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Counts write strobes and measures SCK period and WS run lengths away from the active edge
    always @(negedge clk) begin
        if (wr0 === 1'b1) wrCnt0++;
        if (wr2 === 1'b1) wrCnt2++;
        if (sck0 === 1'b1 && prevSck === 1'b0) begin
            if (lastRise >= 0) sckPeriod = cyc - lastRise;
            lastRise = cyc;
        end
        if (ws0 !== prevWs) begin
            if (prevWs === 1'b1) wsHighLen = wsRun;
            else                 wsLowLen  = wsRun;
            wsRun = 0;
        end
        wsRun++;
        prevSck = sck0;
        prevWs  = ws0;
    end

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic        full;
        int          wr0;
        logic [15:0] din0;
        int          wr2;
        logic [15:0] din2;
        int          ovf0;
        int          ovf2;
    } vec_t;

    vec_t vec [NV];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Mic serial data for frame position b: left word at bits 1..24, right at 33..56, ones elsewhere
    function automatic logic micBit(input logic [23:0] lw, input logic [23:0] rw, input int b);
        if (b >= 1 && b <= 24)       return lw[24-b];
        else if (b >= 33 && b <= 56) return rw[56-b];
        else                         return 1'b1;
    endfunction

    task automatic waitFall(output bit ok);
        logic prev;
        prev = sck0;
        ok   = 1'b0;
        for (int i = 0; i < 4*CLK_DIV + 4; i++) begin
            @(posedge clk); #1;
            if (prev === 1'b1 && sck0 === 1'b0) begin
                ok = 1'b1;
                break;
            end
            prev = sck0;
        end
        if (!ok) begin
            nApplied++;
            nMiss++;
            $display("[TB] FAIL sckFallTimeout: got no falling SCK edge within %0d clks", 4*CLK_DIV + 4);
        end
    endtask

    // Drives one frame (or its first stopAt bits) starting at bit 0, optionally toggling enable
    task automatic applyStimulus(input logic [23:0] lw, input logic [23:0] rw, input logic full,
                                 input int stopAt, input int dropAt, input int raiseAt);
        bit ok;
        fifo_full = full;
        for (int b = 0; b < stopAt; b++) begin
            if (b == dropAt)  enable = 1'b0;
            if (b == raiseAt) enable = 1'b1;
            i2s_sd = micBit(lw, rw, b);
            waitFall(ok);
            if (!ok) return;
        end
    endtask

    task automatic resetDut();
        @(posedge clk); #1;
        rst = 1'b1; enable = 1'b0; fifo_full = 1'b0; i2s_sd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w0, w2, n;
        bit sawHigh;

        rst = 1'b1; enable = 1'b0; fifo_full = 1'b0; i2s_sd = 1'b0;

        vec[0]  = '{24'h000100, 24'h000000, 1'b0, 1, 16'h0001, 0, 16'h0000, 0, 0};
        vec[1]  = '{24'h000200, 24'h000000, 1'b1, 0, 16'h0001, 0, 16'h0000, 1, 0};
        vec[2]  = '{24'h7FFF00, 24'h000000, 1'b0, 1, 16'h7FFF, 1, 16'h7FFF, 1, 0};
        vec[3]  = '{24'h123456, 24'hABCDEF, 1'b0, 1, 16'h1234, 1, 16'h1234, 1, 0};
        vec[4]  = '{24'h800055, 24'hFFFFFF, 1'b0, 1, 16'h8000, 1, 16'h8000, 1, 0};
        vec[5]  = '{24'hFFFFFF, 24'h000000, 1'b1, 0, 16'h8000, 0, 16'h8000, 2, 1};
        vec[6]  = '{24'h00FF00, 24'h000000, 1'b1, 0, 16'h8000, 0, 16'h8000, 3, 2};
        vec[7]  = '{24'h000000, 24'h000000, 1'b1, 0, 16'h8000, 0, 16'h8000, 4, 3};
        vec[8]  = '{24'hABCDEF, 24'h000000, 1'b0, 1, 16'hABCD, 1, 16'hABCD, 4, 3};
        vec[9]  = '{24'h000000, 24'hFFFFFF, 1'b0, 1, 16'h0000, 1, 16'h0000, 4, 3};
        vec[10] = '{24'hFFFF00, 24'h000001, 1'b0, 1, 16'hFFFF, 1, 16'hFFFF, 4, 3};
        vec[11] = '{24'h5A5A5A, 24'hA5A5A5, 1'b0, 1, 16'h5A5A, 1, 16'h5A5A, 4, 3};

        resetDut();
        checkOutput("rst_sck0", sck0, 1'b0);
        checkOutput("rst_ws0",  ws0,  1'b0);
        checkOutput("rst_wr0",  wr0,  1'b0);
        checkOutput("rst_din0", din0, 16'h0000);
        checkOutput("rst_sck2", sck2, 1'b0);
`ifdef I2S_MIC_OVF_CNT_EN
        checkOutput("rst_ovf0", ovf0, 16'h0000);
`endif

        // Basic capture, SCK timing and WS duty, no startup frames on dut0
        w0 = wrCnt0; w2 = wrCnt2;
        i2s_sd = 1'b1;
        enable = 1'b1;
        n = 0;
        for (int i = 1; i <= 4*CLK_DIV; i++) begin
            @(posedge clk); #1;
            if (sck0 === 1'b1) begin
                n = i;
                break;
            end
        end
        checkOutput("A_firstRiseClks", n, CLK_DIV + 1);
        applyStimulus(24'h123456, 24'h000000, 1'b0, 64, -1, -1);
        checkOutput("A_wrCount0", wrCnt0 - w0, 1);
        checkOutput("A_din0", din0, 16'h1234);
        checkOutput("A_sckPeriod", sckPeriod, 2*CLK_DIV);
        applyStimulus(24'h000000, 24'h000000, 1'b0, 64, -1, -1);
        checkOutput("A_wsLowClks", wsLowLen, 64*CLK_DIV*2/2);
        checkOutput("A_wsHighClks", wsHighLen, 256);
        checkOutput("A_wrCount2", wrCnt2 - w2, 0);

        // Table of back-to-back frames from a fresh start
        resetDut();
        enable = 1'b1;
        for (int i = 0; i < NV; i++) begin
            w0 = wrCnt0; w2 = wrCnt2;
            applyStimulus(vec[i].left, vec[i].right, vec[i].full, 64, -1, -1);
            checkOutput($sformatf("v%0d_wr0", i), wrCnt0 - w0, vec[i].wr0);
            checkOutput($sformatf("v%0d_din0", i), din0, vec[i].din0);
            checkOutput($sformatf("v%0d_wr2", i), wrCnt2 - w2, vec[i].wr2);
            checkOutput($sformatf("v%0d_din2", i), din2, vec[i].din2);
`ifdef I2S_MIC_OVF_CNT_EN
            checkOutput($sformatf("v%0d_ovf0", i), ovf0, vec[i].ovf0);
            checkOutput($sformatf("v%0d_ovf2", i), ovf2, vec[i].ovf2);
`endif
        end

`ifdef I2S_MIC_OVF_CNT_EN
        // Overflow counter saturation
        force dut0.ovfCnt_q = 16'hFFFF;
        #1 release dut0.ovfCnt_q;
        w0 = wrCnt0;
        applyStimulus(24'h111111, 24'h000000, 1'b1, 64, -1, -1);
        checkOutput("S_ovf0Sat", ovf0, 16'hFFFF);
        checkOutput("S_ovf2", ovf2, 16'h0004);
        checkOutput("S_wrCount0", wrCnt0 - w0, 0);
`endif

        // Enable low mid-frame but high again at the frame boundary: stays running, no startup
        w0 = wrCnt0; w2 = wrCnt2;
        applyStimulus(24'h0BAD00, 24'h000000, 1'b0, 64, 10, 63);
        checkOutput("R_wrCount2a", wrCnt2 - w2, 1);
        checkOutput("R_din2a", din2, 16'h0BAD);
        w2 = wrCnt2;
        applyStimulus(24'h0C0DE0, 24'h000000, 1'b0, 64, -1, -1);
        checkOutput("R_wrCount2b", wrCnt2 - w2, 1);
        checkOutput("R_din2b", din2, 16'h0C0D);
        checkOutput("R_wrCount0", wrCnt0 - w0, 2);

        // Enable dropped at bit 10: frame completes with its write, then idle
        w0 = wrCnt0; w2 = wrCnt2;
        applyStimulus(24'h432100, 24'h000000, 1'b0, 64, 10, -1);
        checkOutput("B_wrCount0", wrCnt0 - w0, 1);
        checkOutput("B_din0", din0, 16'h4321);
        checkOutput("B_wrCount2", wrCnt2 - w2, 1);
        checkOutput("B_sckAtEnd", sck0, 1'b0);
        sawHigh = 1'b0;
        for (int i = 0; i < 4*CLK_DIV; i++) begin
            @(posedge clk); #1;
            if (sck0 !== 1'b0 || ws0 !== 1'b0) sawHigh = 1'b1;
        end
        checkOutput("B_idleQuiet", sawHigh, 1'b0);

        // Reset at bit 12 of a running frame: partial word never written, outputs cleared
        w0 = wrCnt0;
        enable = 1'b1;
        applyStimulus(24'hA5A5A5, 24'h000000, 1'b0, 12, -1, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("C_sck0", sck0, 1'b0);
        checkOutput("C_ws0",  ws0,  1'b0);
        checkOutput("C_wr0",  wr0,  1'b0);
        checkOutput("C_din0", din0, 16'h0000);
        checkOutput("C_din2", din2, 16'h0000);
`ifdef I2S_MIC_OVF_CNT_EN
        checkOutput("C_ovf0", ovf0, 16'h0000);
`endif
        enable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (64*CLK_DIV) @(posedge clk);
        #1;
        checkOutput("C_noWrite", wrCnt0 - w0, 0);
        checkOutput("C_sckIdle", sck0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule

// File: doc/i2s_mic_capture.md
I2S_MIC_CAPTURE -- requirements
Module: i2s_mic_capture

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCK half-period, legal range 2..255.
REQ-002 Parameter STARTUP_FRAMES, default 2: frames discarded after each IDLE->RUN transition, legal range 0..255.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 enable  input  1  capture request; level-sensitive.
REQ-006 i2s_sck  output  1  I2S bit clock to microphone.
REQ-007 i2s_ws  output  1  I2S word select; 0 = left slot, 1 = right slot.
REQ-008 i2s_sd  input  1  serial data from microphone; left-channel mic, MSB first, 24 valid bits.
REQ-009 fifo_full  input  1  full flag from the downstream sample FIFO.
REQ-010 wr_en  output  1  one-clk write strobe to the FIFO.
REQ-011 din  output  16  sample to the FIFO, two's complement; valid when wr_en=1.
REQ-012 ovf_cnt  output  16  dropped-sample count; present only with I2S_MIC_OVF_CNT_EN.

Function
REQ-013 States: IDLE and RUN; in IDLE, i2s_sck=0, i2s_ws=0, wr_en=0, and the divider, bit and frame counters are held at 0.
REQ-014 IDLE->RUN on the first clk with enable=1; the first SCK rising edge occurs CLK_DIV clks later.
REQ-015 SCK: divider counts 0..CLK_DIV-1 and toggles i2s_sck on wrap, giving SCK period 2*CLK_DIV clks and fs = f_clk/(128*CLK_DIV).
REQ-016 Frame: 64 SCK periods; 6-bit bit counter advances on each SCK falling edge; i2s_ws = bit_cnt[5] (bits 0..31 low, 32..63 high).
REQ-017 i2s_sd is sampled on the clk at which i2s_sck rises; left-slot bit_cnt 1..24 shift in the 24-bit word MSB first; bit 0 and bits 25..63 are ignored.
REQ-018 On the clk after bit_cnt=24 is sampled: if the frame is not a startup frame and fifo_full=0, then wr_en=1 for exactly one clk, with din = word[23:8] (truncation, no rounding).
REQ-019 If fifo_full=1 at that clk: no write occurs, the sample is dropped, and the overflow counter increments.
REQ-020 Startup frames: the first STARTUP_FRAMES frames after entering RUN produce no wr_en and no overflow count; the frame counter saturates at STARTUP_FRAMES.
REQ-021 Exactly one write attempt per frame; wr_en is never asserted twice within 64 SCK periods.
REQ-022 enable=0 during RUN: the current frame completes (including its write, if pending), then the block returns to IDLE at bit_cnt 63->0; enable=1 again at that boundary keeps it in RUN without re-applying startup frames.
REQ-023 din holds its last written value between writes.

Reset
REQ-024 rst=1 on any clk edge, including mid-frame: state=IDLE, i2s_sck=0, i2s_ws=0, wr_en=0, din=0, shift register=0, all counters=0, ovf_cnt=0.
REQ-025 Reset takes priority over enable; a partial word captured before reset is never written.

Configuration
REQ-026 With I2S_MIC_OVF_CNT_EN defined: port ovf_cnt exists, counts dropped samples, saturates at 16'hFFFF, and clears only on rst.
REQ-027 Without I2S_MIC_OVF_CNT_EN: no ovf_cnt port and no counter logic; dropped samples are silently discarded and all other behaviour is identical.

Structure
REQ-028 Shared package mic_pkg: SLOT_BITS=32, FRAME_BITS=64, MIC_WORD_BITS=24, SAMPLE_BITS=16, and the IDLE/RUN state encoding.
REQ-029 One sub-module, i2s_sck_gen: divider producing i2s_sck plus single-clk sck_rise/sck_fall strobes, held in reset when the parent is in IDLE.

Verification
REQ-030 CLK_DIV=4, STARTUP_FRAMES=0, mic model sends left word 24'h12_3456 -> SCK period 8 clks, one wr_en with din=16'h1234, ws low for 256 clks then high for 256.
REQ-031 STARTUP_FRAMES=2, words 24'h000100, 24'h000200, 24'h7FFF00 -> only one wr_en, din=16'h7FFF, in the third frame.
REQ-032 Negative word 24'h800055 with fifo_full=0 -> din=16'h8000; right-slot data 24'hFFFFFF is ignored.
REQ-033 fifo_full=1 held for 3 frames (macro on) -> no wr_en, ovf_cnt=3; preload ovf_cnt to 16'hFFFF -> stays at 16'hFFFF.
REQ-034 enable dropped at bit_cnt=10 -> the frame completes and its sample is written, then IDLE with i2s_sck=0 at the frame end; rst at bit_cnt=12 -> no write and all outputs 0 on the next clk.
